// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, IF/ID register and RUN/HALT fetch control for the pipelined MIPS core
// Optional macro IFU_STATS_EN adds the fetch_count and stall_count statistics ports.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [31:0] PC_STEP     = 32'd1,
  parameter logic [31:0] NOP_WORD    = 32'd0,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_next,
  output logic        ifid_valid,
  output logic        halted
`ifdef IFU_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n, instr_n, pc_next_n, pc_inc;
  logic        valid_n, bubble;

  assign pc_inc    = pc + PC_STEP;
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      pc           <= RESET_PC;
      ifid_instr   <= NOP_WORD;
      ifid_pc_next <= 32'd0;
      ifid_valid   <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      ifid_instr   <= instr_n;
      ifid_pc_next <= pc_next_n;
      ifid_valid   <= valid_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    instr_n   = ifid_instr;
    pc_next_n = ifid_pc_next;
    valid_n   = ifid_valid;
    bubble    = 1'b0;
    case (state)
      RUN: begin
        if (redirect) begin
          pc_n   = redirect_pc;
          bubble = 1'b1;
        end else if (stall) begin
          bubble = flush;
        end else if (flush) begin
          pc_n   = pc_inc;
          bubble = 1'b1;
        end else begin
          instr_n   = imem_instr;
          pc_next_n = pc_inc;
          valid_n   = 1'b1;
          // A captured halt freezes the PC on the halt word itself
          if (imem_instr[31:26] == HALT_OPCODE) begin
            state_n = HALT;
          end else begin
            pc_n = pc_inc;
          end
        end
      end
      HALT: begin
        bubble = 1'b1;
        if (redirect) begin
          state_n = RUN;
          pc_n    = redirect_pc;
        end
      end
      default: state_n = RUN;
    endcase
    if (bubble) begin
      instr_n   = NOP_WORD;
      pc_next_n = 32'd0;
      valid_n   = 1'b0;
    end
  end

`ifdef IFU_STATS_EN
  logic stall_edge, fetch_edge;

  assign stall_edge = (state == RUN) && stall && !redirect;
  // A stalled IF/ID keeps its valid bit but is not a new fetch
  assign fetch_edge = valid_n && !stall_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (fetch_edge) fetch_count <= fetch_count + 32'd1;
      if (stall_edge) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch front end of the pipelined MIPS core. It owns the program counter, drives the word address into the combinational instruction memory and captures the returned instruction into the IF/ID pipeline register. It applies stall, flush and branch/jump redirect requests from the hazard unit and EX stage, and freezes fetch on a HALT opcode.

## Interface
Parameters:
- `RESET_PC`, default 32'd0: PC value loaded on reset.
- `PC_STEP`, default 32'd1: sequential PC increment. The PC is a word index into instruction memory.
- `NOP_WORD`, default 32'd0: instruction word inserted as a bubble.
- `HALT_OPCODE`, default 6'b111111: opcode field [31:26] that halts fetch.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold the PC and the IF/ID contents.
- `flush`  in  1  load a bubble into IF/ID.
- `redirect`  in  1  branch/jump taken.
- `redirect_pc`  in  32  target word index.
- `imem_instr`  in  32  instruction from memory for `imem_addr`, available in the same cycle.
- `imem_addr`  out  32  equals `pc`, combinational.
- `pc`  out  32  current PC register.
- `ifid_instr`  out  32  IF/ID instruction.
- `ifid_pc_next`  out  32  IF/ID copy of pc+PC_STEP.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  high in HALT state.
- `fetch_count`  out  32  present only with `IFU_STATS_EN`.
- `stall_count`  out  32  present only with `IFU_STATS_EN`.

## Operation
- FSM with two states, RUN and HALT. Reset enters RUN.
- Per-edge priority in RUN: redirect > stall > normal. `flush` is orthogonal and only affects IF/ID.
  - **redirect:** `pc <= redirect_pc`; IF/ID <= bubble (`NOP_WORD`, `ifid_valid=0`, `ifid_pc_next=0`). `redirect` overrides `stall` in the same cycle.
  - **stall without redirect:** `pc` holds. IF/ID holds, or takes a bubble if `flush`=1.
  - **normal:** `pc <= pc+PC_STEP`, with 32-bit wrap-around. IF/ID <= {`imem_instr`, pc+PC_STEP, valid=1}, or a bubble if `flush`=1.
- HALT detect: a normal, non-flushed capture whose `imem_instr[31:26]==HALT_OPCODE` is loaded into IF/ID with valid=1. On that edge the FSM enters HALT and `pc` holds, not incrementing.
- In HALT:
  - `pc` is frozen.
  - IF/ID loads a bubble every cycle. `stall` is ignored.
  - `halted`=1.
  - `redirect` returns the FSM to RUN with `pc <= redirect_pc` and an IF/ID bubble. This recovers from a halt fetched on a wrong path.
- Reset asserted at any time, including mid-stall or in HALT, immediately forces all reset values.

## Timing
- Reset values: `pc`=`RESET_PC`; `ifid_instr`=`NOP_WORD`; `ifid_pc_next`=0; `ifid_valid`=0; `halted`=0; FSM=RUN; counters=0.
- Fetch latency is one cycle. The instruction at `pc` in cycle N appears on `ifid_instr` after edge N+1.
- Redirect latency is one cycle. `imem_addr` equals `redirect_pc` in the cycle after `redirect` is sampled.
- `halted` rises on the same edge that loads the halt instruction into IF/ID.
- All outputs are registered except `imem_addr`. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `IFU_STATS_EN`.
- **When defined:**
  - `fetch_count` increments on every edge that loads IF/ID with valid=1.
  - `stall_count` increments on every RUN edge with `stall`=1 and `redirect`=0.
  - Both counters are 32-bit, wrap modulo 2^32, and are cleared by `rst`.
- **When undefined:** both ports and both counters are absent. The rest of the behaviour is identical.

## Test plan
- **Reset then sequential run.** Reset with `RESET_PC`=0, then memory words 0..3 with non-halt opcodes and no control inputs. After 4 edges `pc`=4 and `ifid_instr` equals word 3. `ifid_pc_next` steps 1,2,3,4. `ifid_valid`=1 from the first edge.
- **Stall for 2 cycles at `pc`=2.** `pc` stays 2 and IF/ID is unchanged. With `IFU_STATS_EN`, `stall_count`=2. Fetch resumes with word 2.
- **Redirect and flush.**
  - `redirect`=1, `redirect_pc`=5, with `stall`=1 in the same cycle: next `pc`=5, `ifid_valid`=0, `ifid_instr`=0.
  - `flush`=1 alone at `pc`=1: `pc`=2 and an IF/ID bubble.
- **HALT.** Word 3 = 0xFC000000. After the capture edge `halted`=1, `pc`=3, and subsequent IF/ID contents are bubbles. A following `redirect` to 0 clears `halted` and fetch restarts.
- **Asynchronous reset.** Assert `rst` mid-cycle during a stall and during HALT: outputs take their reset values before the next clock edge.
- **Wrap-around.** Redirect to 0xFFFFFFFF, then one normal edge: `pc`=0 and `ifid_pc_next`=0.
